fwd_hazard_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fwd_match.sv | 34 +++
 rtl/fwd_hazard_ctrl.sv | 93 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the forwarding / hazard control slice.
//   fwd_sel_t  : 2-bit select code for the EX-stage 3-to-1 operand muxes
//   pipe_tag_t : destination tag carried down the pipeline {dest, wr, ld}
//   BUBBLE_TAG : tag of an inserted bubble (writes nothing)
//   REG_ZERO   : hard-wired zero register, never forwarded or stalled on
//   produces() : true when a tag is a live producer of a given source register
package cpu_pkg;

    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic              wr;
        logic              ld;
    } pipe_tag_t;

    localparam pipe_tag_t         BUBBLE_TAG = '{dest: '0, wr: 1'b0, ld: 1'b0};
    localparam logic [ADDR_W-1:0] REG_ZERO   = '0;

    function automatic logic produces(input pipe_tag_t tag, input logic [ADDR_W-1:0] src);
        return tag.wr && (tag.dest != REG_ZERO) && (tag.dest == src);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational forwarding comparator for one operand.
//   src     : source register read by the ID instruction
//   ex_tag  : tag of the instruction one stage ahead (EX/MEM at EX time)
//   mem_tag : tag of the instruction two stages ahead (MEM/WB at EX time)
//   en      : operand is actually read; when low the select is FWD_RF
//   sel     : mux select, younger producer wins
module fwd_match
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] src,
    input  pipe_tag_t         ex_tag,
    input  pipe_tag_t         mem_tag,
    input  logic              en,
    output fwd_sel_t          sel
);

    // The load flag only matters for the stall decision, not for the select.
    logic unused_ld;
    assign unused_ld = ex_tag.ld ^ mem_tag.ld;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (en) begin
            if (produces(ex_tag, src)) begin
                sel = FWD_EXMEM;
            end else if (produces(mem_tag, src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall generator, sitting beside ID/EX.
//   clk, rst_n              : clock, synchronous active-low reset
//   id_valid, id_rs, id_rt  : ID instruction and its source registers
//   id_uses_rt              : ID instruction reads rt
//   id_dest, id_reg_write,
//   id_mem_read             : ID instruction's destination tag
//   flush                   : kill the ID instruction (wins over stall)
//   fwd_a_sel, fwd_b_sel    : registered EX operand mux selects
//   stall                   : combinational hold for PC and IF/ID
//   stall_count             : saturating count of stall cycles
module fwd_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = ADDR_W,  // must match the tag width in cpu_pkg
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    pipe_tag_t ex_tag, mem_tag, wb_tag;
    fwd_sel_t  sel_a_next, sel_b_next;
    logic      bubble;

    // The WB-stage producer is covered by the write-before-read register
    // file, so its tag is kept for pipeline completeness but never compared.
    logic unused_wb;
    assign unused_wb = ^wb_tag;

    // Only a load one stage ahead is a hazard: its data is not ready until
    // after EX of the consumer. One stage later it forwards from MEM/WB.
    assign stall = id_valid && !flush && ex_tag.ld &&
                   (produces(ex_tag, id_rs) || (id_uses_rt && produces(ex_tag, id_rt)));

    assign bubble = stall || flush || !id_valid;

    fwd_match u_match_a (
        .src     (id_rs),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .en      (1'b1),
        .sel     (sel_a_next)
    );

    fwd_match u_match_b (
        .src     (id_rt),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .en      (id_uses_rt),
        .sel     (sel_b_next)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, making the tag shift order-independent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_tag      <= BUBBLE_TAG;
            mem_tag     <= BUBBLE_TAG;
            wb_tag      <= BUBBLE_TAG;
            fwd_a_sel   <= FWD_RF;
            fwd_b_sel   <= FWD_RF;
            stall_count <= '0;
        end else begin
            wb_tag  <= mem_tag;
            mem_tag <= ex_tag;
            if (bubble) begin
                ex_tag    <= BUBBLE_TAG;
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                ex_tag    <= '{dest: id_dest, wr: id_reg_write, ld: id_mem_read};
                fwd_a_sel <= sel_a_next;
                fwd_b_sel <= sel_b_next;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus random
// traffic checked against a model that tracks in-flight producers by age.
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_uses_rt, id_reg_write, id_mem_read, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_small, fwd_b_small;
    logic       stall, stall_small;
    logic [15:0] stall_count;
    logic [3:0]  count_small;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
    );

    // Narrow-counter copy sharing all inputs, used to reach saturation quickly.
    fwd_hazard_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_small),
        .fwd_b_sel(fwd_b_small), .stall(stall_small), .stall_count(count_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: instructions issued into EX over the last cycles, youngest first.
    // Age 1 = issued last cycle (forward from EX/MEM), age 2 = MEM/WB.
    logic [4:0] h_dest [3];
    logic       h_wr   [3];
    logic       h_ld   [3];
    logic [1:0] exp_a, exp_b;
    int         exp_cnt;
    logic       exp_stall, obs_stall, obs_stall_small;

    function automatic logic [1:0] producer_age(input logic [4:0] src);
        for (int i = 0; i < 2; i++) begin
            if (h_wr[i] && h_dest[i] != 5'd0 && h_dest[i] == src) return 2'(i + 1);
        end
        return 2'd0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Drives one ID cycle, samples the combinational stall before the edge,
    // then advances the model across the edge.
    task automatic cycle(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] dest, input logic wr,
                         input logic ld, input logic fl, input logic rn);
        logic bub;
        logic [1:0] na, nb;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_dest = dest;
        id_reg_write = wr; id_mem_read = ld; flush = fl; rst_n = rn;
        #1;
        exp_stall = v && !fl && h_ld[0] && h_wr[0] && h_dest[0] != 5'd0 &&
                    (h_dest[0] == rs || (urt && h_dest[0] == rt));
        obs_stall       = stall;
        obs_stall_small = stall_small;
        @(posedge clk);
        #1;
        if (!rn) begin
            for (int i = 0; i < 3; i++) begin
                h_dest[i] = 5'd0; h_wr[i] = 1'b0; h_ld[i] = 1'b0;
            end
            exp_a = 2'd0; exp_b = 2'd0; exp_cnt = 0;
        end else begin
            if (exp_stall) exp_cnt++;
            bub = exp_stall || fl || !v;
            na  = producer_age(rs);
            nb  = urt ? producer_age(rt) : 2'd0;
            exp_a = bub ? 2'd0 : na;
            exp_b = bub ? 2'd0 : nb;
            for (int i = 2; i > 0; i--) begin
                h_dest[i] = h_dest[i-1]; h_wr[i] = h_wr[i-1]; h_ld[i] = h_ld[i-1];
            end
            h_dest[0] = bub ? 5'd0 : dest;
            h_wr[0]   = bub ? 1'b0 : wr;
            h_ld[0]   = bub ? 1'b0 : ld;
        end
    endtask

    task automatic op(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] dest, input logic wr, input logic ld);
        cycle(1'b1, rs, rt, urt, dest, wr, ld, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            h_dest[i] = 5'd0; h_wr[i] = 1'b0; h_ld[i] = 1'b0;
        end
        cycle(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL reset_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        checks++;
        if (stall_count !== 16'd0 || count_small !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d/%0d expected 0/0", stall_count, count_small);
        end
        op(5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        checks++;
        if (obs_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b expected 0", obs_stall);
        end
    endtask

    task automatic test_exmem_fwd();
        logic any_stall;
        idle(2);
        op(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);      // add r3,r1,r2
        any_stall = obs_stall;
        op(5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);      // sub r4,r3,r5
        any_stall |= obs_stall;
        checks++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL exmem_fwd: a=%b b=%b expected 01 00", fwd_a_sel, fwd_b_sel);
        end
        checks++;
        if (any_stall !== 1'b0) begin
            failures++;
            $display("FAIL exmem_nostall: got %b expected 0", any_stall);
        end
    endtask

    task automatic test_memwb_fwd();
        idle(2);
        op(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);      // add r3
        idle(1);                                      // nop
        op(5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);      // or r6,r5,r3
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin
            failures++;
            $display("FAIL memwb_fwd: a=%b b=%b expected 00 10", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use();
        int c0;
        idle(2);
        c0 = int'(stall_count);
        op(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);      // lw r2
        op(5'd2, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);      // add r7,r2,r2 (stalled)
        checks++;
        if (obs_stall !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall: got %b expected 1", obs_stall);
        end
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL load_use_bubble_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        op(5'd2, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);      // add re-presented
        checks++;
        if (obs_stall !== 1'b0) begin
            failures++;
            $display("FAIL load_use_one_bubble: got %b expected 0", obs_stall);
        end
        checks++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
            failures++;
            $display("FAIL load_use_fwd: a=%b b=%b expected 10 10", fwd_a_sel, fwd_b_sel);
        end
        checks++;
        if (int'(stall_count) !== c0 + 1) begin
            failures++;
            $display("FAIL load_use_count: got %0d expected %0d", stall_count, c0 + 1);
        end
    endtask

    task automatic test_r0_and_uses_rt();
        idle(2);
        op(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1);      // lw r0
        op(5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);      // reads r0,r0
        checks++;
        if (obs_stall !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL r0_ignored: stall=%b a=%b b=%b expected 0 00 00",
                     obs_stall, fwd_a_sel, fwd_b_sel);
        end
        idle(2);
        op(5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1);      // lw r9
        op(5'd1, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0);      // addi r8,r1 (rt field = 9)
        checks++;
        if (obs_stall !== 1'b0 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL uses_rt_off: stall=%b b=%b expected 0 00", obs_stall, fwd_b_sel);
        end
    endtask

    task automatic test_younger_wins();
        idle(2);
        op(5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);      // add r9
        op(5'd3, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);      // add r9 again
        op(5'd9, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0);     // reader of r9
        checks++;
        if (fwd_a_sel !== 2'b01) begin
            failures++;
            $display("FAIL younger_wins: a=%b expected 01", fwd_a_sel);
        end
    endtask

    task automatic test_flush_and_reset();
        int c0;
        idle(2);
        c0 = int'(stall_count);
        op(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);      // lw r2
        cycle(1'b1, 5'd2, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);  // use + flush
        checks++;
        if (obs_stall !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL flush_prio: stall=%b a=%b b=%b expected 0 00 00",
                     obs_stall, fwd_a_sel, fwd_b_sel);
        end
        op(5'd2, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);      // the lw is now in MEM
        checks++;
        if (obs_stall !== 1'b0 || fwd_a_sel !== 2'b10 || int'(stall_count) !== c0) begin
            failures++;
            $display("FAIL flush_bubble: stall=%b a=%b cnt=%0d expected 0 10 %0d",
                     obs_stall, fwd_a_sel, stall_count, c0);
        end
        idle(2);
        op(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);      // lw r2
        cycle(1'b1, 5'd2, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);  // stall, reset
        checks++;
        if (obs_stall !== 1'b1 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 ||
            stall_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_stall: stall=%b a=%b b=%b cnt=%0d expected 1 00 00 0",
                     obs_stall, fwd_a_sel, fwd_b_sel, stall_count);
        end
        op(5'd2, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        checks++;
        if (obs_stall !== 1'b0 || fwd_a_sel !== 2'b00) begin
            failures++;
            $display("FAIL after_reset: stall=%b a=%b expected 0 00", obs_stall, fwd_a_sel);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 49) != 0));
            checks++;
            if (obs_stall !== exp_stall || obs_stall_small !== exp_stall ||
                fwd_a_sel !== exp_a || fwd_b_sel !== exp_b ||
                fwd_a_small !== exp_a || fwd_b_small !== exp_b ||
                int'(stall_count) !== sat(exp_cnt, 65535) ||
                int'(count_small) !== sat(exp_cnt, 15)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: stall=%b a=%b b=%b cnt=%0d/%0d expected %b %b %b %0d/%0d",
                             n, obs_stall, fwd_a_sel, fwd_b_sel, stall_count, count_small,
                             exp_stall, exp_a, exp_b, sat(exp_cnt, 65535), sat(exp_cnt, 15));
            end
        end
    endtask

    task automatic test_saturation();
        cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);  // reset
        // lw r2 reading r2, repeated: every second cycle is a load-use stall.
        for (int n = 0; n < 40; n++) op(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        checks++;
        if (stall_count !== 16'd20) begin
            failures++;
            $display("FAIL sat_wide: got %0d expected 20", stall_count);
        end
        checks++;
        if (count_small !== 4'hF) begin
            failures++;
            $display("FAIL sat_narrow: got %0d expected 15", count_small);
        end
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
        exp_a = '0; exp_b = '0; exp_cnt = 0;
        @(negedge clk);
        test_reset();
        test_exmem_fwd();
        test_memwb_fwd();
        test_load_use();
        test_r0_and_uses_rt();
        test_younger_wins();
        test_flush_and_reset();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
